// File: rtl/dsp_simd_accum.sv
// Dual-channel frame accumulator for the packed SIMD DSP multiplier output.
// It sums frame_len unsigned products per channel and presents both totals
// with a valid/ready handshake. Any product that arrives while a result is
// waiting to be taken is discarded and flagged in the sticky overrun bit.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; in_valid is ignored, sums keep last result
// ACC   | summing products; the frame length is latched and fixed
// OUT   | sum0/sum1 valid and held until out_valid && out_ready

module dsp_simd_accum #(
    parameter int DATA_W = 19,
    parameter int CNT_W  = 8,
    parameter int ACC_W  = DATA_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] z0,
    input  logic [DATA_W-1:0] z1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum0,
    output logic [ACC_W-1:0]  sum1,
    output logic              busy,
    output logic              overrun,
    input  logic              clear_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc0_q;
    logic [ACC_W-1:0]   acc1_q;

    logic [ACC_W-1:0]   z0_ext;
    logic [ACC_W-1:0]   z1_ext;
    logic [ACC_W-1:0]   acc0_nxt;
    logic [ACC_W-1:0]   acc1_nxt;
    logic [CNT_W-1:0]   last_cnt;
    logic               is_last;

    // Products are unsigned, so zero-extension keeps the sum exact.
    assign z0_ext   = ACC_W'(z0);
    assign z1_ext   = ACC_W'(z1);
    assign acc0_nxt = acc0_q + z0_ext;
    assign acc1_nxt = acc1_q + z1_ext;

    // A latched length of 0 wraps to all-ones here, which makes the frame
    // 2^CNT_W terms long without any special casing.
    assign last_cnt = len_q - CNT_ONE;
    assign is_last  = (cnt_q == last_cnt);

    assign busy = (state != IDLE);

    // Frame sequencing, accumulation and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            acc0_q    <= '0;
            acc1_q    <= '0;
            sum0      <= '0;
            sum1      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= frame_len;
                        cnt_q  <= '0;
                        acc0_q <= '0;
                        acc1_q <= '0;
                        state  <= ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc0_q <= acc0_nxt;
                        acc1_q <= acc1_nxt;
                        cnt_q  <= cnt_q + CNT_ONE;
                        if (is_last) begin
                            sum0      <= acc0_nxt;
                            sum1      <= acc1_nxt;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Sticky drop flag; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (state == OUT && in_valid) begin
            overrun <= 1'b1;
        end else if (clear_err) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_simd_accum.sv
// Directed bench for dsp_simd_accum: table of whole frames plus hand-written
// sequences for gaps, overrun, mid-frame reset and ignored restarts.

module tb_dsp_simd_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  frame_len;
    logic        in_valid;
    logic [18:0] z0;
    logic [18:0] z1;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] sum0;
    logic [26:0] sum1;
    logic        busy;
    logic        overrun;
    logic        clear_err;

    int checks   = 0;
    int failures = 0;

    dsp_simd_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .z0        (z0),
        .z1        (z1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum0      (sum0),
        .sum1      (sum1),
        .busy      (busy),
        .overrun   (overrun),
        .clear_err (clear_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  len;
        int          nterms;
        logic [18:0] z0_base;
        logic [18:0] z0_step;
        logic [18:0] z1_base;
        logic [18:0] z1_step;
        logic [26:0] exp0;
        logic [26:0] exp1;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic handshake(input string name, input logic [26:0] held0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
        check({name, " busy after handshake"}, {31'd0, busy}, 32'd0);
        check({name, " sum0 held in idle"}, {5'd0, sum0}, {5'd0, held0});
    endtask

    task automatic run_vec(input vec_t v);
        start     = 1'b1;
        frame_len = v.len;
        step();
        start = 1'b0;
        check({v.name, " busy after start"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < v.nterms; i++) begin
            in_valid = 1'b1;
            z0 = v.z0_base + 19'(i) * v.z0_step;
            z1 = v.z1_base + 19'(i) * v.z1_step;
            step();
            if (i < v.nterms - 1)
                check({v.name, " out_valid early"}, {31'd0, out_valid}, 32'd0);
        end
        in_valid = 1'b0;
        check({v.name, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({v.name, " sum0"}, {5'd0, sum0}, {5'd0, v.exp0});
        check({v.name, " sum1"}, {5'd0, sum1}, {5'd0, v.exp1});
        check({v.name, " busy in out"}, {31'd0, busy}, 32'd1);
        step();
        check({v.name, " out_valid held"}, {31'd0, out_valid}, 32'd1);
        check({v.name, " sum1 held"}, {5'd0, sum1}, {5'd0, v.exp1});
        handshake(v.name, v.exp0);
        check({v.name, " overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        logic pattern [6];

        vecs[0] = '{"basic4",   8'd4,   4,   19'd1,       19'd1, 19'd10,      19'd10, 27'd10,        27'd100};
        vecs[1] = '{"len0_256", 8'd0,   256, 19'h7FA01,   19'd0, 19'h7FA01,   19'd0,  27'h7FA0100,   27'h7FA0100};
        vecs[2] = '{"len1_max", 8'd1,   1,   19'h7FFFF,   19'd0, 19'd0,       19'd0,  27'h7FFFF,     27'd0};
        vecs[3] = '{"len3_mix", 8'd3,   3,   19'd5,       19'd0, 19'h7FFFF,   19'd0,  27'd15,        27'h17FFFD};
        vecs[4] = '{"len255",   8'd255, 255, 19'd1,       19'd0, 19'd0,       19'd1,  27'd255,       27'd32385};

        rst_n = 1'b0; start = 1'b0; frame_len = '0; in_valid = 1'b0;
        z0 = '0; z1 = '0; out_ready = 1'b0; clear_err = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);
        check("reset sum0", {5'd0, sum0}, 32'd0);
        check("reset sum1", {5'd0, sum1}, 32'd0);

        // start on the first edge after release
        rst_n = 1'b1; start = 1'b1; frame_len = 8'd1;
        step();
        start = 1'b0;
        check("first start busy", {31'd0, busy}, 32'd1);
        in_valid = 1'b1; z0 = 19'd9; z1 = 19'd3;
        step();
        in_valid = 1'b0;
        check("first frame out_valid", {31'd0, out_valid}, 32'd1);
        check("first frame sum0", {5'd0, sum0}, 32'd9);
        handshake("first frame", 27'd9);

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // in_valid in IDLE is ignored
        in_valid = 1'b1; z0 = 19'd123; z1 = 19'd456;
        repeat (3) step();
        in_valid = 1'b0;
        check("idle in_valid overrun", {31'd0, overrun}, 32'd0);
        check("idle in_valid busy", {31'd0, busy}, 32'd0);
        check("idle in_valid out_valid", {31'd0, out_valid}, 32'd0);
        check("idle in_valid sum0", {5'd0, sum0}, 32'd255);

        // gapped in_valid, invalid cycles carry garbage data
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        start = 1'b1; frame_len = 8'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = pattern[i];
            z0 = pattern[i] ? 19'd5 : 19'd99;
            z1 = pattern[i] ? 19'd2 : 19'd77;
            step();
            if (i < 5) check("gapped out_valid early", {31'd0, out_valid}, 32'd0);
        end
        in_valid = 1'b0;
        check("gapped out_valid", {31'd0, out_valid}, 32'd1);
        check("gapped sum0", {5'd0, sum0}, 32'd15);
        check("gapped sum1", {5'd0, sum1}, 32'd6);
        handshake("gapped", 27'd15);

        // overrun while result is held
        start = 1'b1; frame_len = 8'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1; z0 = 19'd3; z1 = 19'd1;
        step();
        z0 = 19'd4; z1 = 19'd1;
        step();
        check("ovr out_valid", {31'd0, out_valid}, 32'd1);
        z0 = 19'd100; z1 = 19'd100;
        in_valid = 1'b1; step();
        check("ovr set", {31'd0, overrun}, 32'd1);
        in_valid = 1'b0; step();
        in_valid = 1'b1; step();
        in_valid = 1'b0; step();
        step();
        check("ovr sum0 held", {5'd0, sum0}, 32'd7);
        check("ovr sum1 held", {5'd0, sum1}, 32'd2);
        check("ovr out_valid held", {31'd0, out_valid}, 32'd1);
        check("ovr sticky", {31'd0, overrun}, 32'd1);
        clear_err = 1'b1; step();
        check("ovr cleared", {31'd0, overrun}, 32'd0);
        in_valid = 1'b1; step();
        check("ovr set wins over clear", {31'd0, overrun}, 32'd1);
        in_valid = 1'b0; step();
        clear_err = 1'b0;
        check("ovr cleared again", {31'd0, overrun}, 32'd0);
        in_valid = 1'b1;
        handshake("ovr", 27'd7);
        in_valid = 1'b0;
        check("ovr on handshake cycle", {31'd0, overrun}, 32'd1);
        clear_err = 1'b1; step(); clear_err = 1'b0;
        check("ovr final clear", {31'd0, overrun}, 32'd0);

        // asynchronous reset mid-frame
        start = 1'b1; frame_len = 8'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1; z0 = 19'd50; z1 = 19'd60;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset sum0", {5'd0, sum0}, 32'd0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step();
        check("post reset out_valid", {31'd0, out_valid}, 32'd0);
        check("post reset busy", {31'd0, busy}, 32'd0);
        start = 1'b1; frame_len = 8'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1; z0 = 19'd7; z1 = 19'd1;
        step(); step();
        in_valid = 1'b0;
        check("post reset out_valid done", {31'd0, out_valid}, 32'd1);
        check("post reset sum0", {5'd0, sum0}, 32'd14);
        check("post reset sum1", {5'd0, sum1}, 32'd2);
        handshake("post reset", 27'd14);

        // start during ACC is ignored
        start = 1'b1; frame_len = 8'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1; z0 = 19'd1; z1 = 19'd0;
        step();
        start = 1'b1; frame_len = 8'd1; z0 = 19'd2;
        step();
        start = 1'b0; frame_len = 8'd9;
        check("restart ignored out_valid", {31'd0, out_valid}, 32'd0);
        z0 = 19'd3;
        step();
        in_valid = 1'b0;
        check("restart ignored done", {31'd0, out_valid}, 32'd1);
        check("restart ignored sum0", {5'd0, sum0}, 32'd6);
        handshake("restart", 27'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_simd_accum.md
DSP_SIMD_ACCUM -- requirements
Module: dsp_simd_accum

Interface
REQ-001 Parameter DATA_W, default 19, SHALL set the width of each SIMD product input.
REQ-002 Parameter CNT_W, default 8, SHALL set the frame-length field width (max 2^CNT_W terms).
REQ-003 Parameter ACC_W, default DATA_W+CNT_W (27), SHALL set the width of each sum output.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle pulse that opens a frame.
REQ-007 frame_len  input  CNT_W  number of terms per frame; 0 SHALL mean 2^CNT_W.
REQ-008 in_valid  input  1  z0/z1 hold a valid product pair this cycle.
REQ-009 z0  input  DATA_W  channel-0 unsigned product from the SIMD DSP.
REQ-010 z1  input  DATA_W  channel-1 unsigned product from the SIMD DSP.
REQ-011 out_valid  output  1  sum0/sum1 hold a completed frame result.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum0  output  ACC_W  channel-0 frame sum.
REQ-014 sum1  output  ACC_W  channel-1 frame sum.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 overrun  output  1  sticky flag: a product was dropped.
REQ-017 clear_err  input  1  synchronous clear of overrun.

Function
REQ-018 FSM SHALL have exactly three states: IDLE, ACC, OUT.
REQ-019 IDLE: start=1 SHALL latch frame_len, zero both accumulators and the term counter, and move to ACC; in_valid in IDLE SHALL be ignored without flagging.
REQ-020 ACC: each cycle with in_valid=1 SHALL add zero-extended z0 to acc0 and z1 to acc1 and increment the counter; cycles with in_valid=0 SHALL hold all state.
REQ-021 ACC: the in_valid cycle on which the counter equals latched length-1 SHALL load acc+z into sum0/sum1, set out_valid on the next edge, and move to OUT.
REQ-022 Latency: out_valid SHALL be high exactly one clock after the final term is sampled.
REQ-023 start while in ACC or OUT SHALL be ignored; frame_len changes after latching SHALL have no effect.
REQ-024 OUT: sum0/sum1/out_valid SHALL be held stable until out_valid&&out_ready; that edge SHALL clear out_valid and return to IDLE.
REQ-025 OUT: any in_valid=1 cycle (including the handshake cycle) SHALL drop the pair and set overrun.
REQ-026 overrun SHALL stay set until clear_err=1; set and clear in the same cycle: set SHALL win.
REQ-027 Sums SHALL be exact; with defaults max sum 256*(2^19-1) fits 27 bits, no wrap or saturation logic.
REQ-028 sum0/sum1 SHALL keep the last completed frame value while in IDLE and ACC.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, out_valid=0, busy=0, overrun=0, sum0=sum1=0, accumulators and counter=0.
REQ-030 Reset asserted mid-frame or during OUT SHALL discard the partial frame/result; no out_valid SHALL follow release.
REQ-031 First start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-032 frame_len=4, in_valid continuous, z0=1,2,3,4, z1=10,20,30,40 -> out_valid one clock after 4th term, sum0=10, sum1=100, busy high from start until handshake.
REQ-033 frame_len=0, 256 terms z0=z1=0x7FA01 (1023*511) -> sum0=sum1=0x7FA0100, no truncation.
REQ-034 frame_len=3 with in_valid gapped (1,0,0,1,0,1), z0=5 each -> sum0=15, out_valid one clock after 3rd valid.
REQ-035 Hold out_ready=0 for 5 cycles in OUT while in_valid=1 for 2 of them -> sums unchanged, overrun=1; clear_err=1 -> overrun=0; then out_ready=1 -> IDLE.
REQ-036 Assert rst_n=0 after 2 of 4 terms, release, start new frame_len=2 z0=7,7 -> sum0=14, no stale contribution.
REQ-037 Pulse start during ACC with different frame_len -> ignored; frame completes at originally latched length.
